// File: rtl/flopenr_pipe.sv
// flopenr_pipe
// ------------
// Elastic register pipeline of DEPTH stages, each holding WIDTH data bits
// plus a valid bit. Entries enter at stage 0 and leave from stage DEPTH-1.
// The stall chain lets entries slide forward into empty stages even while
// the output is stalled, so bubbles collapse toward the output.
//
// Ports
//   clk       : clock, all state updates on the rising edge
//   rst       : synchronous active-high reset; clears data, valid, count
//   en        : 1 = the output stage is consumed this cycle
//   flush     : synchronous discard of every held entry
//   in_valid  : d carries a valid entry
//   d         : input data
//   in_ready  : combinational; entry accepted when in_valid & in_ready
//   q         : data of the output stage (registered)
//   out_valid : valid bit of the output stage (registered)
//   count     : number of valid stages (registered)
//
// DEPTH must be at least 2.

module flopenr_pipe #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic                         flush,
    input  logic                         in_valid,
    input  logic [WIDTH-1:0]             d,
    output logic                         in_ready,
    output logic [WIDTH-1:0]             q,
    output logic                         out_valid,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] data_q [DEPTH];
    logic [WIDTH-1:0] data_d [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] valid_d;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;

    logic [DEPTH-1:0] rdy;
    logic             accept;
    logic             consume;

    // A stage may load when it is empty or when the stage after it is
    // itself able to move; the chain starts at the output stage, which
    // frees up when en consumes it.
    always_comb begin
        rdy = '0;
        rdy[DEPTH-1] = en | ~valid_q[DEPTH-1];
        for (int i = DEPTH - 2; i >= 0; i--) begin
            rdy[i] = ~valid_q[i] | rdy[i+1];
        end
    end

    assign in_ready = rdy[0] & ~flush & ~rst;
    assign accept   = in_valid & in_ready;
    assign consume  = en & valid_q[DEPTH-1];

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        count_d = count_q;

        // Stage 0 always loads d when ready; its valid bit only reflects
        // whether the entry was actually accepted.
        if (rdy[0]) begin
            data_d[0]  = d;
            valid_d[0] = accept;
        end

        for (int i = 1; i < DEPTH; i++) begin
            if (rdy[i]) begin
                data_d[i]  = data_q[i-1];
                valid_d[i] = valid_q[i-1];
            end
        end

        // Accept and consume are each at most one per cycle, so the count
        // cannot overflow DEPTH or drop below zero.
        count_d = count_q + CW'(accept) - CW'(consume);

        // Flush drops every entry; data registers are left to whatever the
        // normal path computed since invalid data is don't-care.
        if (flush) begin
            valid_d = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
            end
            valid_q <= '0;
            count_q <= '0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            count_q <= count_d;
        end
    end

    assign q         = data_q[DEPTH-1];
    assign out_valid = valid_q[DEPTH-1];
    assign count     = count_q;

endmodule

// File: tb/tb_flopenr_pipe.sv
// Directed testbench for flopenr_pipe (WIDTH=4, DEPTH=3). Accepted entries
// are pushed onto a scoreboard queue; each consumption pops the head and
// compares it with q. The queue size doubles as the expected count.

module tb_flopenr_pipe;

    logic       clk;
    logic       rst;
    logic       en;
    logic       flush;
    logic       in_valid;
    logic [3:0] d;
    logic       in_ready;
    logic [3:0] q;
    logic       out_valid;
    logic [1:0] count;

    int n_checks = 0;
    int n_fail   = 0;
    logic [3:0] exp_q [$];
    logic [3:0] head;

    flopenr_pipe #(.WIDTH(4), .DEPTH(3)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .flush    (flush),
        .in_valid (in_valid),
        .d        (d),
        .in_ready (in_ready),
        .q        (q),
        .out_valid(out_valid),
        .count    (count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check in_ready, update the scoreboard,
    // clock the DUT, then check count against the scoreboard depth.
    task automatic step(input logic s_rst, input logic s_en, input logic s_flush,
                        input logic s_vld, input logic [3:0] s_d,
                        input logic exp_rdy, input string tag);
        rst      = s_rst;
        en       = s_en;
        flush    = s_flush;
        in_valid = s_vld;
        d        = s_d;
        #1;
        chk({tag, "_in_ready"}, 32'(in_ready), 32'(exp_rdy));
        if (!s_rst && !s_flush && s_en && out_valid === 1'b1) begin
            chk({tag, "_pop_nonempty"}, 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                head = exp_q.pop_front();
                chk({tag, "_q_pop"}, 32'(q), 32'(head));
            end
        end
        if (!s_rst && !s_flush && s_vld && exp_rdy) exp_q.push_back(s_d);
        if (s_rst || s_flush) exp_q.delete();
        @(posedge clk);
        #1;
        chk({tag, "_count"}, 32'(count), 32'(exp_q.size()));
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; flush = 1'b0; in_valid = 1'b1; d = 4'h5;

        // Reset with in_valid=1 and en=1
        step(1, 1, 0, 1, 4'h5, 0, "reset");
        chk("reset_q", 32'(q), 32'h0);
        chk("reset_out_valid", 32'(out_valid), 32'h0);
        rst = 1'b0; in_valid = 1'b0; #1;
        chk("post_reset_in_ready", 32'(in_ready), 32'h1);

        // Streaming with en=1
        begin
            logic [3:0] seq [7];
            seq[0] = 4'h0; seq[1] = 4'h1; seq[2] = 4'h2; seq[3] = 4'h3;
            seq[4] = 4'h9; seq[5] = 4'hD; seq[6] = 4'hF;
            for (int i = 0; i < 7; i++) begin
                step(0, 1, 0, 1, seq[i], 1, "stream");
                chk("stream_out_valid", 32'(out_valid), 32'(i >= 2));
                chk("stream_count", 32'(count), 32'((i + 1 > 3) ? 3 : i + 1));
            end
        end
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 4'h0, 1, "stream_drain");
        chk("stream_drained_ov", 32'(out_valid), 32'h0);

        // Stall / full
        step(0, 0, 0, 1, 4'h1, 1, "stall_push1");
        step(0, 0, 0, 1, 4'h2, 1, "stall_push2");
        step(0, 0, 0, 1, 4'h3, 1, "stall_push3");
        step(0, 0, 0, 1, 4'h4, 0, "stall_full");
        chk("stall_full_count", 32'(count), 32'h3);
        chk("stall_full_q", 32'(q), 32'h1);
        step(0, 1, 0, 1, 4'h4, 1, "stall_release");
        chk("stall_release_q", 32'(q), 32'h2);
        chk("stall_release_count", 32'(count), 32'h3);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 4'h0, 1, "stall_drain");
        chk("stall_drained_ov", 32'(out_valid), 32'h0);

        // Bubble collapse with en=0
        step(0, 0, 0, 1, 4'hA, 1, "bubble_pushA");
        step(0, 0, 0, 0, 4'h0, 1, "bubble_idle1");
        step(0, 0, 0, 0, 4'h0, 1, "bubble_idle2");
        chk("bubble_A_at_q", 32'(q), 32'hA);
        chk("bubble_A_valid", 32'(out_valid), 32'h1);
        step(0, 0, 0, 1, 4'hB, 1, "bubble_pushB");
        step(0, 0, 0, 0, 4'h0, 1, "bubble_pack");
        chk("bubble_count", 32'(count), 32'h2);
        chk("bubble_ov", 32'(out_valid), 32'h1);
        step(0, 1, 0, 0, 4'h0, 1, "bubble_popA");
        // B was packed into s[1], so one edge brings it to the output
        chk("bubble_B_at_q", 32'(q), 32'hB);
        chk("bubble_B_valid", 32'(out_valid), 32'h1);
        step(0, 1, 0, 0, 4'h0, 1, "bubble_popB");
        chk("bubble_empty", 32'(out_valid), 32'h0);

        // Flush with en and in_valid also asserted
        step(0, 0, 0, 1, 4'h3, 1, "flush_fill1");
        step(0, 0, 0, 1, 4'h6, 1, "flush_fill2");
        step(0, 0, 0, 1, 4'h8, 1, "flush_fill3");
        chk("flush_full_count", 32'(count), 32'h3);
        step(0, 1, 1, 1, 4'h7, 0, "flush");
        chk("flush_ov", 32'(out_valid), 32'h0);
        chk("flush_count", 32'(count), 32'h0);
        step(0, 0, 0, 0, 4'h0, 1, "flush_idle1");
        step(0, 0, 0, 0, 4'h0, 1, "flush_idle2");
        chk("flush_not_accepted", 32'(out_valid), 32'h0);

        // Mid-stream reset together with flush
        step(0, 1, 0, 1, 4'h1, 1, "mid_push1");
        step(0, 1, 0, 1, 4'h2, 1, "mid_push2");
        step(0, 1, 0, 1, 4'h3, 1, "mid_push3");
        step(0, 1, 0, 1, 4'h4, 1, "mid_push4");
        step(1, 1, 1, 1, 4'h5, 0, "mid_reset");
        chk("mid_reset_q", 32'(q), 32'h0);
        chk("mid_reset_ov", 32'(out_valid), 32'h0);
        step(0, 1, 0, 1, 4'h6, 1, "restart_push6");
        step(0, 1, 0, 1, 4'h7, 1, "restart_push7");
        step(0, 1, 0, 1, 4'h8, 1, "restart_push8");
        chk("restart_first_q", 32'(q), 32'h6);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 4'h0, 1, "restart_drain");
        chk("restart_drained_ov", 32'(out_valid), 32'h0);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/flopenr_pipe.md
FLOPENR_PIPE -- requirements
Module: flopenr_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the data width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 3, giving the number of register stages; legal range is DEPTH >= 2.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port en, input, 1 bit: output-advance enable; 1 means the output stage is consumed this cycle.
REQ-006 The block SHALL have port flush, input, 1 bit: synchronous discard of all held entries.
REQ-007 The block SHALL have port in_valid, input, 1 bit: d carries a valid entry.
REQ-008 The block SHALL have port d, input, WIDTH bits: input data.
REQ-009 The block SHALL have port in_ready, output, 1 bit: combinational; an entry is accepted on a rising edge where in_valid=1 and in_ready=1.
REQ-010 The block SHALL have port q, output, WIDTH bits: data of the output stage (stage DEPTH-1), driven directly from a register.
REQ-011 The block SHALL have port out_valid, output, 1 bit: the valid bit of the output stage.
REQ-012 The block SHALL have port count, output, clog2(DEPTH+1) bits: the number of valid stages, driven directly from a register.

Function
REQ-013 The block SHALL hold stages s[0..DEPTH-1], each with a data register and a valid bit; s[0] is the input stage and s[DEPTH-1] is the output stage.
REQ-014 The block SHALL compute stage readiness combinationally as: rdy[DEPTH-1] = en OR NOT v[DEPTH-1], and rdy[i] = NOT v[i] OR rdy[i+1] for i < DEPTH-1.
REQ-015 The block SHALL drive in_ready = rdy[0] AND NOT flush AND NOT rst.
REQ-016 When rdy[i]=1, stage i SHALL load the data and valid bit of stage i-1; stage 0 loads d and the value (in_valid AND in_ready).
REQ-017 When rdy[i]=0, stage i SHALL hold its data and valid bit.
REQ-018 When a stage loads an invalid source, its valid bit SHALL clear; its data register SHALL still load the source data, and that data is don't-care.
REQ-019 Bubble collapse: with en=0, valid entries SHALL advance one stage per cycle into empty stages until they are packed against the output stage.
REQ-020 Entry order SHALL be preserved; no entry is dropped or duplicated except by flush or rst.
REQ-021 Latency: with the pipe empty, an entry accepted at edge k SHALL present out_valid=1 with its data on q after edge k+DEPTH-1, regardless of en.
REQ-022 With en=1 and in_valid=1 held every cycle, the block SHALL accept one entry per cycle with no bubbles, and count SHALL saturate at DEPTH.
REQ-023 Full condition: when all stages are valid and en=0, in_ready SHALL be 0 and all stages SHALL hold.
REQ-024 count SHALL update per edge as next = count + accept - (en AND out_valid); it never exceeds DEPTH and never wraps below 0.
REQ-025 en=1 with out_valid=0 SHALL consume nothing, and count SHALL be unaffected by the en term.
REQ-026 flush=1 SHALL, on the next edge, clear every valid bit and set count=0; d is not accepted in that cycle; data registers are don't-care.
REQ-027 flush and en asserted together SHALL behave as flush alone.

Reset
REQ-028 rst=1 on a rising edge SHALL clear every valid bit and every data register to 0 and set count=0, giving q=0, out_valid=0 and count=0.
REQ-029 rst SHALL take priority over flush, en and in_valid; while rst=1, in_ready=0.
REQ-030 After rst deasserts, the first edge with in_valid=1 SHALL accept (in_ready=1).

Verification (WIDTH=4, DEPTH=3)
REQ-031 Reset: assert rst for one edge with in_valid=1 and en=1 -> q=0, out_valid=0, count=0, in_ready=0 during rst and 1 after.
REQ-032 Stream: en=1, push d=0,1,2,3,9,D,F on consecutive edges -> q shows the same sequence starting 2 edges after the first accept, out_valid=1 continuously, and count stays at 3 once full.
REQ-033 Stall/full: en=0, push 1,2,3,4 -> 1,2,3 accepted, in_ready=0 before 4, count=3, q=1 held; then en=1 for one edge -> q=2, 4 accepted, count=3.
REQ-034 Bubble collapse: en=0, push A, then 2 idle cycles, then push B -> A reaches q after 2 edges, B packs behind it in s[1], count=2, out_valid=1.
REQ-035 Flush: pipe holding 3 entries, flush=1 with in_valid=1 and en=1 -> next cycle count=0, out_valid=0, and the input is not accepted.
REQ-036 Mid-operation reset: during streaming, assert rst and flush together -> reset values per REQ-028; the stream restarts cleanly with correct order.
